isp_flow_control: RTL and testbench
===================================

Name: isp_flow_control

Overview:
- Pixel re-packer at the front of the ISP pipeline, after the CSI-2 byte/lane merger.
- Accepts 0–4 pixels per cycle, packed in a data-type-dependent layout. Each pixel is unpacked into a 24-bit slot and written to an internal pixel FIFO.
- The FIFO is drained in groups of exactly pixel_per_clk_i pixels onto a 96-bit, 4-slot output stream with a per-slot strobe and a downstream stall.
- Single clock domain; no CDC.

Parameters:
- DEPTH, 16, pixel FIFO capacity in pixels. Power of two, ≥ 8.

Ports:
- pixel_clk_i  in  1  sole clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- data_type_i  in  6  CSI-2 data type: 0x1E YUV422_8, 0x24 RGB888, 0x22 RGB565, 0x2A RAW8, 0x2B RAW10.
- byte_data_i  in  48  packed input pixels.
- byte_data_valid_i  in  4  per-pixel valid, bit k = input pixel k.
- pixel_per_clk_i  in  3  output group size; legal values 1–4.
- pixel_stream_stall_i  in  1  downstream stall.
- pixel_data_o  out  96  slot k = bits [24k+23:24k].
- pixel_data_valid_o  out  4  per-slot strobe.
- overflow_o  out  1  sticky FIFO-overflow flag.

Behaviour:
- Reset (reset_i high at a clock edge):
  - FIFO emptied.
  - pixel_data_o = 0, pixel_data_valid_o = 0, overflow_o = 0.
- Input layout, pixel k, LSB-aligned in byte_data_i; max pixels per type:
  - RAW8: bits [8k+7:8k], max 4.
  - RAW10: bits [10k+9:10k], max 4.
  - RGB565 / YUV422_8: bits [16k+15:16k], max 2.
  - RGB888: bits [24k+23:24k], max 2.
  - Any other type: 0 pixels accepted.
- Unpacked pixel: zero-extended to 24 bits, no colour expansion.
- Input count N_in = number of contiguous 1s in byte_data_valid_i starting at bit 0, capped at the type maximum.
  - Bits after the first 0 are ignored. Example: 4'b1011 gives N_in = 2 for RAW8.
- Pixels are pushed in index order (pixel 0 first).
- Group size G = pixel_per_clk_i when it is 1–4; 0 or >4 is treated as G = 1.
- Pop rule, evaluated each cycle on the current occupancy:
  - If occupancy ≥ G and pixel_stream_stall_i = 0, pop the G oldest pixels.
  - Next cycle: oldest pixel in slot 0, next in slot 1, and so on; pixel_data_valid_o = (1<<G)-1.
  - Otherwise next cycle: pixel_data_valid_o = 0 and pixel_data_o holds its previous value.
  - Unused slots in a group are driven 0.
- Partial groups (occupancy < G) stay in the FIFO until more pixels arrive; there is no timeout flush.
- Latency: a pixel pushed at edge n can appear on the outputs at the earliest after edge n+1. Outputs are registered.
- Simultaneous push and pop in one cycle:
  - Free space = DEPTH − occupancy + popped.
  - Pixels beyond free space are dropped, newest first, and overflow_o is set.
  - overflow_o stays 1 until reset.
- A change of pixel_per_clk_i or data_type_i mid-stream takes effect on the next cycle. FIFO contents are preserved and are not re-formatted.
- Reset asserted mid-stream discards all buffered pixels.

Test Plan:
- RAW8, G = 4: byte_data_i[31:0] = 0x44332211, valid = 4'b1111 for one cycle -> next cycle pixel_data_o = {0x000044, 0x000033, 0x000022, 0x000011}, valid = 4'b1111.
- RGB888, G = 1: push 2 pixels, 0xAABBCC (pixel 0) and 0x112233 (pixel 1), then idle -> two consecutive cycles with slot 0 = 0xAABBCC, then 0x112233, valid = 4'b0001 each; then valid = 0.
- RAW10, G = 2, 5 cycles of 4 pixels -> 10 groups of 2 in input order, slot values = 10-bit fields, valid = 4'b0011. With stall held 3 cycles: no strobes during the stall, no loss, order kept.
- YUV422_8, G = 4: push 1 pixel, then 2 pixels -> no output (occupancy 3); push 1 more -> one group of 4, valid = 4'b1111.
- Overflow, DEPTH = 16: RAW8 ×4, G = 4, stall = 1 for 5 cycles -> 16 pixels kept, 4 dropped, overflow_o = 1. Release stall -> 4 groups of the first 16 pixels; overflow_o stays 1 until reset_i.
- Edge cases -> required response:
  - Valid 4'b0101, RAW8: exactly 1 pixel accepted.
  - data_type_i = 0: nothing accepted.
  - pixel_per_clk_i = 0: behaves as G = 1.
  - Reset with 3 buffered pixels: all outputs 0 next cycle, and the buffered pixels never appear.

Source files
------------

// File: rtl/isp_flow_control.sv
`default_nettype none
// ============================================================================
// Module   : isp_flow_control
// Purpose  : Unpacks 0-4 CSI-2 pixels per cycle into a 24-bit pixel FIFO and
//            drains it in fixed-size groups onto a 4-slot output stream.
// Revision : 1.0  initial release
// ============================================================================
module isp_flow_control #(
  parameter int DEPTH = 16
) (
  input  logic        pixel_clk_i,
  input  logic        reset_i,
  input  logic [5:0]  data_type_i,
  input  logic [47:0] byte_data_i,
  input  logic [3:0]  byte_data_valid_i,
  input  logic [2:0]  pixel_per_clk_i,
  input  logic        pixel_stream_stall_i,
  output logic [95:0] pixel_data_o,
  output logic [3:0]  pixel_data_valid_o,
  output logic        overflow_o
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  localparam logic [5:0] c_dt_yuv422_8 = 6'h1E;
  localparam logic [5:0] c_dt_rgb888   = 6'h24;
  localparam logic [5:0] c_dt_rgb565   = 6'h22;
  localparam logic [5:0] c_dt_raw8     = 6'h2A;
  localparam logic [5:0] c_dt_raw10    = 6'h2B;

  logic [23:0]     w_pix [4];
  logic [2:0]      w_type_max;
  logic [2:0]      w_run;
  logic [2:0]      w_n_in;
  logic [2:0]      w_grp;
  logic [2:0]      w_n_push;
  logic [3:0]      w_mask;
  logic            w_pop;
  logic            w_drop;
  logic [c_cw-1:0] w_grp_ext;
  logic [c_cw-1:0] w_pop_n;
  logic [c_cw-1:0] w_free;
  logic [c_cw-1:0] w_n_in_ext;
  logic [95:0]     w_group;

  logic [23:0]     r_mem [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;
  logic [95:0]     r_pixel_data;
  logic [3:0]      r_pixel_valid;
  logic            r_overflow;

  // Per-type unpack: every lane is zero-extended into a 24-bit slot.
  always_comb begin
    w_type_max = 3'd0;
    for (int k = 0; k < 4; k++) w_pix[k] = '0;
    case (data_type_i)
      c_dt_raw8: begin
        w_type_max = 3'd4;
        for (int k = 0; k < 4; k++) w_pix[k] = {16'h0, byte_data_i[8*k +: 8]};
      end
      c_dt_raw10: begin
        w_type_max = 3'd4;
        for (int k = 0; k < 4; k++) w_pix[k] = {14'h0, byte_data_i[10*k +: 10]};
      end
      c_dt_rgb565, c_dt_yuv422_8: begin
        w_type_max = 3'd2;
        for (int k = 0; k < 2; k++) w_pix[k] = {8'h0, byte_data_i[16*k +: 16]};
      end
      c_dt_rgb888: begin
        w_type_max = 3'd2;
        for (int k = 0; k < 2; k++) w_pix[k] = byte_data_i[24*k +: 24];
      end
      default: w_type_max = 3'd0;
    endcase
  end

  // Only the unbroken run of valids from bit 0 counts.
  always_comb begin
    casez (byte_data_valid_i)
      4'b1111: w_run = 3'd4;
      4'b?111: w_run = 3'd3;
      4'b??11: w_run = 3'd2;
      4'b???1: w_run = 3'd1;
      default: w_run = 3'd0;
    endcase
    w_n_in = (w_run > w_type_max) ? w_type_max : w_run;
  end

  always_comb begin
    case (pixel_per_clk_i)
      3'd1, 3'd2, 3'd3, 3'd4: w_grp = pixel_per_clk_i;
      default:                w_grp = 3'd1;
    endcase
    case (w_grp)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd3:    w_mask = 4'b0111;
      default: w_mask = 4'b1111;
    endcase
  end

  // Space freed by this cycle's pop is usable by this cycle's push.
  always_comb begin
    w_grp_ext  = c_cw'(w_grp);
    w_pop      = (r_count >= w_grp_ext) && !pixel_stream_stall_i;
    w_pop_n    = w_pop ? w_grp_ext : '0;
    w_free     = c_depth - r_count + w_pop_n;
    w_n_in_ext = c_cw'(w_n_in);
    w_drop     = w_n_in_ext > w_free;
    w_n_push   = w_drop ? w_free[2:0] : w_n_in;
  end

  always_comb begin
    w_group = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_mask[k]) w_group[24*k +: 24] = r_mem[r_rd_ptr + c_aw'(k)];
    end
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge pixel_clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < w_n_push) r_mem[r_wr_ptr + c_aw'(k)] <= w_pix[k];
      end
    end
  end

  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_aw'(w_n_push);
      r_count  <= r_count + c_cw'(w_n_push) - w_pop_n;
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + c_aw'(w_grp);
        r_pixel_data  <= w_group;
        r_pixel_valid <= w_mask;
      end else begin
        r_pixel_valid <= '0;
      end
    end
  end

  assign pixel_data_o       = r_pixel_data;
  assign pixel_data_valid_o = r_pixel_valid;
  assign overflow_o         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_isp_flow_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_isp_flow_control
// Purpose  : Directed vector table plus multi-cycle sequences for isp_flow_control.
// Revision : 1.0  initial release
// ============================================================================
module tb_isp_flow_control;

  localparam logic [5:0] c_raw8   = 6'h2A;
  localparam logic [5:0] c_raw10  = 6'h2B;
  localparam logic [5:0] c_rgb888 = 6'h24;
  localparam logic [5:0] c_yuv    = 6'h1E;

  localparam logic [95:0] c_d1 = 96'h000044_000033_000022_000011;
  localparam logic [95:0] c_d2 = 96'h000000_000000_000000_AABBCC;
  localparam logic [95:0] c_d3 = 96'h000000_000000_000000_112233;
  localparam logic [95:0] c_d4 = 96'h00DEF0_005678_009ABC_001234;
  localparam logic [95:0] c_d5 = 96'h000000_000000_000000_000011;
  localparam logic [95:0] c_d6 = 96'h000000_000000_000000_0000AA;
  localparam logic [95:0] c_d7 = 96'h000000_000000_000000_00000B;
  localparam logic [95:0] c_d8 = 96'h0000CC_0000BB_0000AA_000099;

  typedef struct {
    logic        rst;
    logic [5:0]  dt;
    logic [47:0] bd;
    logic [3:0]  v;
    logic [2:0]  ppc;
    logic        st;
    logic [95:0] ed;
    logic [3:0]  ev;
    logic        eo;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  dt;
  logic [47:0] bd;
  logic [3:0]  bv;
  logic [2:0]  ppc;
  logic        stall;
  logic [95:0] pd;
  logic [3:0]  pv;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  vec_t        vecs[$];
  logic [9:0]  exp_q[$];
  logic [47:0] b;
  logic [95:0] eg;
  logic [9:0]  e0;
  logic [9:0]  e1;
  int          groups;
  logic        st_now;

  isp_flow_control #(.DEPTH(16)) dut (
    .pixel_clk_i          (clk),
    .reset_i              (rst),
    .data_type_i          (dt),
    .byte_data_i          (bd),
    .byte_data_valid_i    (bv),
    .pixel_per_clk_i      (ppc),
    .pixel_stream_stall_i (stall),
    .pixel_data_o         (pd),
    .pixel_data_valid_o   (pv),
    .overflow_o           (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [5:0] t, input logic [47:0] d,
                              input logic [3:0] v, input logic [2:0] p, input logic s,
                              input logic [95:0] ed, input logic [3:0] ev, input logic eo);
    vec_t x;
    x.rst = r; x.dt = t; x.bd = d; x.v = v; x.ppc = p; x.st = s;
    x.ed = ed; x.ev = ev; x.eo = eo;
    return x;
  endfunction

  function automatic logic [9:0] r10v(input int p);
    return 10'((p * 53 + 17) % 1024);
  endfunction

  task automatic drive(input logic r, input logic [5:0] t, input logic [47:0] d,
                       input logic [3:0] v, input logic [2:0] p, input logic s);
    rst = r; dt = t; bd = d; bv = v; ppc = p; stall = s;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] t, input logic [47:0] d,
                      input logic [3:0] v, input logic [2:0] p, input logic s);
    @(negedge clk);
    drive(r, t, d, v, p, s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, c_raw8, '0, '0, 3'd4, 1'b0);

    vecs.push_back(mk(1, c_raw8,   48'h0,            4'h0, 3'd4, 0, 96'h0, 4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h44332211,     4'hF, 3'd4, 0, 96'h0, 4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd4, 0, c_d1,  4'hF, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd4, 0, c_d1,  4'h0, 0));
    vecs.push_back(mk(0, c_rgb888, 48'h112233AABBCC, 4'h3, 3'd1, 0, c_d1,  4'h0, 0));
    vecs.push_back(mk(0, c_rgb888, 48'h0,            4'h0, 3'd1, 0, c_d2,  4'h1, 0));
    vecs.push_back(mk(0, c_rgb888, 48'h0,            4'h0, 3'd1, 0, c_d3,  4'h1, 0));
    vecs.push_back(mk(0, c_rgb888, 48'h0,            4'h0, 3'd1, 0, c_d3,  4'h0, 0));
    vecs.push_back(mk(0, c_yuv,    48'h1234,         4'h1, 3'd4, 0, c_d3,  4'h0, 0));
    vecs.push_back(mk(0, c_yuv,    48'h56789ABC,     4'h3, 3'd4, 0, c_d3,  4'h0, 0));
    vecs.push_back(mk(0, c_yuv,    48'hDEF0,         4'h1, 3'd4, 0, c_d3,  4'h0, 0));
    vecs.push_back(mk(0, c_yuv,    48'h0,            4'h0, 3'd4, 0, c_d4,  4'hF, 0));
    vecs.push_back(mk(0, c_yuv,    48'h0,            4'h0, 3'd4, 0, c_d4,  4'h0, 0));
    // Broken valid run: only pixel 0 may enter.
    vecs.push_back(mk(0, c_raw8,   48'h44332211,     4'h5, 3'd1, 0, c_d4,  4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd1, 0, c_d5,  4'h1, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd1, 0, c_d5,  4'h0, 0));
    vecs.push_back(mk(0, 6'h00,    48'h44332211,     4'hF, 3'd1, 0, c_d5,  4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd1, 0, c_d5,  4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0BAA,         4'h3, 3'd0, 0, c_d5,  4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd0, 0, c_d6,  4'h1, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd0, 0, c_d7,  4'h1, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd0, 0, c_d7,  4'h0, 0));
    // Three pixels buffered, then reset must discard them.
    vecs.push_back(mk(0, c_raw8,   48'h776655,       4'h7, 3'd4, 0, c_d7,  4'h0, 0));
    vecs.push_back(mk(1, c_raw8,   48'h0,            4'h0, 3'd4, 0, 96'h0, 4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h99,           4'h1, 3'd4, 0, 96'h0, 4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'hCCBBAA,       4'h7, 3'd4, 0, 96'h0, 4'h0, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd4, 0, c_d8,  4'hF, 0));
    vecs.push_back(mk(0, c_raw8,   48'h0,            4'h0, 3'd4, 0, c_d8,  4'h0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].dt, vecs[i].bd, vecs[i].v, vecs[i].ppc, vecs[i].st);
      chk($sformatf("vec%0d", i), {pd, pv, ovf}, {vecs[i].ed, vecs[i].ev, vecs[i].eo});
    end

    // RAW10, G = 2: five full input beats, stall held for three cycles mid-drain.
    groups = 0;
    for (int c = 0; c < 30; c++) begin
      b = '0;
      if (c < 5) begin
        for (int k = 0; k < 4; k++) begin
          b[10*k +: 10] = r10v(4 * c + k);
          exp_q.push_back(r10v(4 * c + k));
        end
      end
      st_now = (c >= 6) && (c <= 8);
      step(1'b0, c_raw10, b, (c < 5) ? 4'hF : 4'h0, 3'd2, st_now);
      if (st_now) begin
        chk("r10_stall_strobe", pv, 4'h0);
      end else if (pv == 4'b0011) begin
        if (exp_q.size() < 2) begin
          chk("r10_extra_group", pv, 4'h0);
        end else begin
          e0 = exp_q.pop_front();
          e1 = exp_q.pop_front();
          chk($sformatf("r10_group%0d", groups), pd, {48'h0, 14'h0, e1, 14'h0, e0});
          groups++;
        end
      end else if (pv != 4'h0) begin
        chk("r10_strobe_shape", pv, 4'b0011);
      end
    end
    chk("r10_group_count", groups, 10);
    chk("r10_no_overflow", ovf, 1'b0);

    // Overflow: fill 16 under stall, fifth beat of 4 is dropped.
    step(1'b1, c_raw8, '0, '0, 3'd4, 1'b0);
    chk("ovf_reset", {pd, pv, ovf}, 101'h0);
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 4; k++) b[8*k +: 8] = 8'(4 * c + k + 1);
      b[47:32] = '0;
      step(1'b0, c_raw8, b, 4'hF, 3'd4, 1'b1);
      chk($sformatf("ovf_fill%0d_strobe", c), pv, 4'h0);
      if (c == 3) chk("ovf_not_yet", ovf, 1'b0);
      if (c == 4) chk("ovf_set", ovf, 1'b1);
    end
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) eg[24*k +: 24] = 24'(4 * g + k + 1);
      step(1'b0, c_raw8, '0, '0, 3'd4, 1'b0);
      chk($sformatf("ovf_drain%0d", g), {pd, pv, ovf}, {eg, 4'hF, 1'b1});
    end
    step(1'b0, c_raw8, '0, '0, 3'd4, 1'b0);
    chk("ovf_dropped_gone", {pv, ovf}, {4'h0, 1'b1});
    step(1'b1, c_raw8, '0, '0, 3'd4, 1'b0);
    chk("ovf_cleared", ovf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
